ext_mem_access_ctrl: RTL
========================

// Module: ext_mem_access_ctrl
// PURPOSE
//   Target-side controller for the external memory-access interface of top_control_8.
//   Decodes the host's mode levels: start_2 = IRAM load, start_3 = DRAM load,
//   start_4 = DRAM readback, start = run.
//   Turns the host's multi-cycle level strobes into single-cycle, registered write/read
//   pulses toward the 8 core IRAMs and the shared DRAM, and returns readback data to the host.
//   Sits between the external pins and the memory ports; the cores only see core_run.
// PARAMETERS
//   NUM_CORES  8   number of IRAM banks / per-core write strobes
//   ADDR_W     9   external and memory address width
//   DATA_W     16  instruction and data word width
//   RD_LAT     1   DRAM read latency in cycles, dram_re to dram_rdata valid (1..4)
// PORTS
//   clock           in   1          system clock, rising edge
//   reset           in   1          asynchronous, active-high
//   start           in   1          run-mode level
//   start_2         in   1          IRAM-load mode level
//   start_3         in   1          DRAM-load mode level
//   start_4         in   1          readback mode level
//   addr_ext        in   ADDR_W     host address
//   data_in_ins     in   DATA_W     host instruction word
//   data_in_dram    in   DATA_W     host data word
//   iram_write_ext  in   NUM_CORES  per-core IRAM write strobe, level, held >=2 cycles
//   dram_write_ext  in   1          DRAM write strobe, level
//   read_en_ext     in   1          DRAM read strobe, level
//   dram_rdata      in   DATA_W     DRAM read data
//   iram_we         out  NUM_CORES  one-hot IRAM write pulse
//   iram_addr       out  ADDR_W     IRAM write address
//   iram_wdata      out  DATA_W     IRAM write data
//   dram_we         out  1          DRAM write pulse
//   dram_re         out  1          DRAM read pulse
//   dram_addr       out  ADDR_W     DRAM address
//   dram_wdata      out  DATA_W     DRAM write data
//   dram_out        out  DATA_W     readback word to host (dram_in_1)
//   rd_valid        out  1          dram_out valid
//   core_run        out  1          cores enabled
//   mode            out  3          0 IDLE, 1 IRAM_LOAD, 2 DRAM_LOAD, 3 READBACK, 4 RUN
//   word_count      out  ADDR_W+1   writes accepted in current load mode
//   err_multi       out  1          sticky: >1 IRAM strobe rose together
//   err_mode        out  1          sticky: conflicting modes, or strobe outside its mode
// BEHAVIOUR
//   - Reset: all outputs 0; state IDLE; strobe history registers 0.
//   - Inputs are synchronous to clock. No synchronizer.
//   - Mode decode priority: start_2 > start_3 > start_4 > start; none asserted = IDLE.
//     The state register takes the decoded mode at every rising edge.
//     >1 mode level high in a cycle: take the priority winner and set err_mode.
//   - Edge detect: each strobe is registered once per cycle.
//     A rising edge is (current & ~previous); holding a strobe high gives exactly one event.
//   - IRAM_LOAD: exactly one iram_write_ext bit rises in cycle N.
//     In N+1: iram_we gets that one-hot bit; iram_addr/iram_wdata hold addr_ext/data_in_ins
//     as sampled in cycle N; word_count increments.
//     Two or more bits rise together: no write, set err_multi.
//   - DRAM_LOAD: dram_write_ext rises in cycle N.
//     In N+1: dram_we=1; dram_addr/dram_wdata hold addr_ext/data_in_dram as sampled in N;
//     word_count increments.
//   - READBACK: read_en_ext rises in cycle N.
//     In N+1: dram_re=1 and dram_addr=addr_ext.
//     In N+1+RD_LAT: dram_out<=dram_rdata and rd_valid=1.
//     rd_valid stays 1 (dram_out held) until read_en_ext is low, then clears next cycle.
//     A new rise while a read is pending is ignored.
//   - RUN: core_run=1 for every cycle in RUN, 0 in every other state.
//     In RUN all strobes are ignored and no memory pulses are issued.
//   - A strobe rise in any mode other than its own: ignored, set err_mode.
//   - Mode change:
//     - A write pulse scheduled for N+1 is still issued.
//     - A pending read is dropped and rd_valid clears.
//     - word_count clears on entry to IRAM_LOAD or DRAM_LOAD.
//   - word_count saturates at 2^ADDR_W and does not wrap.
//   - Addresses are passed through unchanged; no range check.
//   - err_multi and err_mode clear only on reset.
//   - Reset asserted mid-operation: pending pulses are cancelled immediately (async clear).
// TESTING
//   - Reset -> every output 0 and mode=0, including while strobes are toggling.
//   - start_2=1; addr_ext=5, data_in_ins=16'h1234; bit2 high for 4 cycles
//     -> one-cycle iram_we=8'b0000_0100, iram_addr=5, iram_wdata=16'h1234, word_count=1.
//   - start_3=1; 3 writes to addr 1..3 with data 10,20,30
//     -> exactly 3 dram_we pulses with matching addr/data; word_count=3.
//   - start_4=1, RD_LAT=2, DRAM returns 16'hBEEF at addr 7; read_en_ext held 5 cycles
//     -> dram_re 1 cycle; rd_valid rises 3 cycles after the rise; dram_out=16'hBEEF;
//        rd_valid clears 1 cycle after the fall.
//   - IRAM_LOAD with bits 0 and 1 rising together -> no iram_we, err_multi=1;
//     a dram_write_ext rise in the same mode -> no dram_we, err_mode=1.
//   - start=1 with iram_write_ext toggling -> core_run=1 and no iram_we;
//     start_2 and start raised together -> mode=1 and err_mode=1.

Source files
------------

// File: rtl/ext_mem_access_ctrl.sv
// Target-side controller for the external memory-access interface: decodes host mode
// levels and turns level strobes into single-cycle registered IRAM/DRAM pulses.
module ext_mem_access_ctrl #(
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 start_2,
  input  logic                 start_3,
  input  logic                 start_4,
  input  logic [ADDR_W-1:0]    addr_ext,
  input  logic [DATA_W-1:0]    data_in_ins,
  input  logic [DATA_W-1:0]    data_in_dram,
  input  logic [NUM_CORES-1:0] iram_write_ext,
  input  logic                 dram_write_ext,
  input  logic                 read_en_ext,
  input  logic [DATA_W-1:0]    dram_rdata,
  output logic [NUM_CORES-1:0] iram_we,
  output logic [ADDR_W-1:0]    iram_addr,
  output logic [DATA_W-1:0]    iram_wdata,
  output logic                 dram_we,
  output logic                 dram_re,
  output logic [ADDR_W-1:0]    dram_addr,
  output logic [DATA_W-1:0]    dram_wdata,
  output logic [DATA_W-1:0]    dram_out,
  output logic                 rd_valid,
  output logic                 core_run,
  output logic [2:0]           mode,
  output logic [ADDR_W:0]      word_count,
  output logic                 err_multi,
  output logic                 err_mode
);

  localparam logic [2:0] MODE_IDLE = 3'd0;
  localparam logic [2:0] MODE_IRAM = 3'd1;
  localparam logic [2:0] MODE_DRAM = 3'd2;
  localparam logic [2:0] MODE_READ = 3'd3;
  localparam logic [2:0] MODE_RUN  = 3'd4;
  localparam logic [NUM_CORES-1:0] CORE_ZERO = {NUM_CORES{1'b0}};
  localparam logic [NUM_CORES-1:0] CORE_ONE  = {{(NUM_CORES-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] WC_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] WC_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0] RD_LAT_V = 3'(RD_LAT);

  function automatic logic is_onehot(input logic [NUM_CORES-1:0] vec);
    return (vec != CORE_ZERO) && ((vec & (vec - CORE_ONE)) == CORE_ZERO);
  endfunction

  logic [2:0]           mode_r;
  logic [2:0]           mode_nxt_s;
  logic [2:0]           lvl_cnt_s;
  logic                 multi_mode_s;
  logic [NUM_CORES-1:0] iram_prev_r;
  logic                 dram_wr_prev_r;
  logic                 rd_prev_r;
  logic [NUM_CORES-1:0] iram_rise_s;
  logic                 dram_wr_rise_s;
  logic                 rd_rise_s;
  logic                 iram_ev_s;
  logic                 iram_multi_s;
  logic                 dram_ev_s;
  logic                 rd_issue_s;
  logic                 wrong_mode_s;
  logic                 load_entry_s;
  logic                 rd_pending_s;
  logic [2:0]           rd_cnt_r;
  logic [ADDR_W:0]      wc_nxt_s;

  assign lvl_cnt_s      = {2'b00, start} + {2'b00, start_2} + {2'b00, start_3} + {2'b00, start_4};
  assign multi_mode_s   = (lvl_cnt_s > 3'd1);
  assign iram_rise_s    = iram_write_ext & ~iram_prev_r;
  assign dram_wr_rise_s = dram_write_ext & ~dram_wr_prev_r;
  assign rd_rise_s      = read_en_ext & ~rd_prev_r;
  // A read is in flight until captured, and blocks new reads while its data is presented.
  assign rd_pending_s   = (rd_cnt_r != 3'd0) || rd_valid;
  assign load_entry_s   = (mode_nxt_s != mode_r) && ((mode_nxt_s == MODE_IRAM) || (mode_nxt_s == MODE_DRAM));
  assign mode           = mode_r;

  // Mode state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_r <= MODE_IDLE;
    end else begin
      mode_r <= mode_nxt_s;
    end
  end

  // Next-state decode: fixed priority over the host mode levels
  always_comb begin
    mode_nxt_s = MODE_IDLE;
    if (start_2) begin
      mode_nxt_s = MODE_IRAM;
    end else if (start_3) begin
      mode_nxt_s = MODE_DRAM;
    end else if (start_4) begin
      mode_nxt_s = MODE_READ;
    end else if (start) begin
      mode_nxt_s = MODE_RUN;
    end else begin
      mode_nxt_s = MODE_IDLE;
    end
  end

  // Output decode: qualify strobe edges against the mode of the current cycle
  always_comb begin
    iram_ev_s    = 1'b0;
    iram_multi_s = 1'b0;
    dram_ev_s    = 1'b0;
    rd_issue_s   = 1'b0;
    wrong_mode_s = 1'b0;
    case (mode_nxt_s)
      MODE_IRAM: begin
        if (iram_rise_s != CORE_ZERO) begin
          iram_ev_s    = is_onehot(iram_rise_s);
          iram_multi_s = ~is_onehot(iram_rise_s);
        end else begin
          iram_ev_s    = 1'b0;
          iram_multi_s = 1'b0;
        end
        wrong_mode_s = dram_wr_rise_s | rd_rise_s;
      end
      MODE_DRAM: begin
        dram_ev_s    = dram_wr_rise_s;
        wrong_mode_s = (iram_rise_s != CORE_ZERO) | rd_rise_s;
      end
      MODE_READ: begin
        rd_issue_s   = rd_rise_s & ~rd_pending_s;
        wrong_mode_s = (iram_rise_s != CORE_ZERO) | dram_wr_rise_s;
      end
      default: begin
        wrong_mode_s = (iram_rise_s != CORE_ZERO) | dram_wr_rise_s | rd_rise_s;
      end
    endcase
  end

  // Word count: restart on load-mode entry, then count accepted writes up to the ceiling
  always_comb begin
    wc_nxt_s = word_count;
    if (load_entry_s) begin
      wc_nxt_s = WC_ZERO;
    end else begin
      wc_nxt_s = word_count;
    end
    if ((iram_ev_s || dram_ev_s) && (wc_nxt_s != WC_MAX)) begin
      wc_nxt_s = wc_nxt_s + WC_ONE;
    end else begin
      wc_nxt_s = wc_nxt_s;
    end
  end

  // Strobe history, memory pulses, readback pipeline and sticky errors
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iram_prev_r    <= CORE_ZERO;
      dram_wr_prev_r <= 1'b0;
      rd_prev_r      <= 1'b0;
      iram_we        <= CORE_ZERO;
      iram_addr      <= {ADDR_W{1'b0}};
      iram_wdata     <= {DATA_W{1'b0}};
      dram_we        <= 1'b0;
      dram_re        <= 1'b0;
      dram_addr      <= {ADDR_W{1'b0}};
      dram_wdata     <= {DATA_W{1'b0}};
      dram_out       <= {DATA_W{1'b0}};
      rd_valid       <= 1'b0;
      rd_cnt_r       <= 3'd0;
      core_run       <= 1'b0;
      word_count     <= WC_ZERO;
      err_multi      <= 1'b0;
      err_mode       <= 1'b0;
    end else begin
      iram_prev_r    <= iram_write_ext;
      dram_wr_prev_r <= dram_write_ext;
      rd_prev_r      <= read_en_ext;
      iram_we        <= iram_ev_s ? iram_rise_s : CORE_ZERO;
      dram_we        <= dram_ev_s;
      dram_re        <= rd_issue_s;
      core_run       <= (mode_nxt_s == MODE_RUN);
      word_count     <= wc_nxt_s;
      err_multi      <= err_multi | iram_multi_s;
      err_mode       <= err_mode | wrong_mode_s | multi_mode_s;
      if (iram_ev_s) begin
        iram_addr  <= addr_ext;
        iram_wdata <= data_in_ins;
      end
      if (dram_ev_s) begin
        dram_addr  <= addr_ext;
        dram_wdata <= data_in_dram;
      end else if (rd_issue_s) begin
        dram_addr  <= addr_ext;
      end
      // Leaving readback drops any in-flight read and withdraws presented data
      if (mode_nxt_s != MODE_READ) begin
        rd_cnt_r <= 3'd0;
        rd_valid <= 1'b0;
      end else if (rd_issue_s) begin
        rd_cnt_r <= 3'd1;
      end else if (rd_cnt_r != 3'd0) begin
        if (rd_cnt_r == RD_LAT_V) begin
          dram_out <= dram_rdata;
          rd_valid <= 1'b1;
          rd_cnt_r <= 3'd0;
        end else begin
          rd_cnt_r <= rd_cnt_r + 3'd1;
        end
      end else if (rd_valid && !read_en_ext) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule
